// File: rtl/regm_mp_if.sv
// regm_mp_if: bus bundle between the pipeline and the regm_mp register file.
//   master : decode/writeback side; drives read addresses, the write port and
//            clear requests, and receives read data and busy.
//   slave  : register file side.
// Signals:
//   clear_i  request a full clear of the array
//   raddr_i  packed read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata_o  packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   write_i  write enable
//   waddr_i  write address
//   wdata_i  write data
//   busy_o   clear sequence running; writes are ignored while high
interface regm_mp_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned NB_READ_PORTS = 2
);

  logic                                clear_i;
  logic [NB_READ_PORTS*ADDR_WIDTH-1:0] raddr_i;
  logic [NB_READ_PORTS*DATA_WIDTH-1:0] rdata_o;
  logic                                write_i;
  logic [ADDR_WIDTH-1:0]               waddr_i;
  logic [DATA_WIDTH-1:0]               wdata_i;
  logic                                busy_o;

  modport master (
    output clear_i,
    output raddr_i,
    output write_i,
    output waddr_i,
    output wdata_i,
    input  rdata_o,
    input  busy_o
  );

  modport slave (
    input  clear_i,
    input  raddr_i,
    input  write_i,
    input  waddr_i,
    input  wdata_i,
    output rdata_o,
    output busy_o
  );

endinterface

// File: rtl/regm_mp.sv
// regm_mp: parametrised multi-port register file for the decode/writeback path.
// One write port, NB_READ_PORTS combinational read ports, optional hardwired
// zero entry, optional write-to-read forwarding, and a clear sequencer that
// zeroes every entry after reset or on request.
// Ports:
//   clk_i  clock, all state updates on the rising edge
//   rst_i  synchronous active-low reset
//   bus    regm_mp_if slave modport (read ports, write port, clear, busy)
module regm_mp #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned NB_READ_PORTS = 2,
  parameter int unsigned ZERO_REG      = 1,
  parameter int unsigned BYPASS        = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  regm_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]   cnt_d;
  logic                    we_c;
  logic                    wzero_c;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [NB_READ_PORTS*DATA_WIDTH-1:0] rdata_c;

  // Write to the hardwired zero entry is discarded.
  assign wzero_c = (ZERO_REG != 0) && (bus.waddr_i == '0);

  // State and clear counter.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, clear counter and write enable.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_c    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (bus.clear_i) begin
          cnt_d = '0;
        end else if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          // Last entry zeroed this edge; park the counter, no second pass.
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (bus.clear_i) begin
          // Clear wins over a write on the same edge.
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (bus.write_i && !wzero_c) begin
          we_c = 1'b1;
        end
      end
    endcase
  end

  // Storage array; untouched while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (state_q == ST_CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (we_c) begin
        mem_q[bus.waddr_i] <= bus.wdata_i;
      end
    end
  end

  // Per-port combinational read with clear masking, zero entry and bypass.
  for (genvar p = 0; p < NB_READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd_c;

    assign ra = bus.raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd_c = '0;
      if (state_q == ST_CLEAR) begin
        rd_c = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rd_c = '0;
      end else if ((BYPASS != 0) && bus.write_i && !bus.clear_i &&
                   (bus.waddr_i == ra)) begin
        rd_c = bus.wdata_i;
      end else begin
        rd_c = mem_q[ra];
      end
    end

    assign rdata_c[p*DATA_WIDTH +: DATA_WIDTH] = rd_c;
  end

  assign bus.rdata_o = rdata_c;
  assign bus.busy_o  = (state_q == ST_CLEAR);

endmodule
